// File: rtl/axil_pkg.sv
// rtl/axil_pkg.sv - AXI4-Lite response codes and master state encoding
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    RSP     = 3'd5
  } axil_state_e;

endpackage

// File: rtl/axil_timeout_ctr.sv
// rtl/axil_timeout_ctr.sv - wait-cycle counter that flags an unresponsive slave
module axil_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic s_axi_aclk,
  input  logic s_axi_aresetn,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] count_q, count_d;

  // Fires during the last permitted wait cycle so the FSM leaves on that edge.
  assign expired = count_en && (count_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_en && !expired) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/axil_master.sv
// rtl/axil_master.sv - single-outstanding AXI4-Lite master; AXIL_MASTER_TIMEOUT_EN adds a wait timeout
module axil_master
  import axil_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    s_axi_aclk,
  input  logic                    s_axi_aresetn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic                    rsp_timeout,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [2:0]              m_axi_awprot,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [2:0]              m_axi_arprot,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready
);

  localparam int STRB_W = DATA_WIDTH / 8;

  if (!(DATA_WIDTH == 32 || DATA_WIDTH == 64) || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("axil_master: DATA_WIDTH must be 32 or 64 and TIMEOUT_CYCLES at least 1");
  end

  axil_state_e         state_q, state_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic                awvalid_q, awvalid_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic                wvalid_q, wvalid_d;
  logic                bready_q, bready_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic                arvalid_q, arvalid_d;
  logic                rready_q, rready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]          rsp_resp_q, rsp_resp_d;

`ifdef AXIL_MASTER_TIMEOUT_EN
  logic rsp_timeout_q, rsp_timeout_d;
  logic timeout_hit;

  axil_timeout_ctr #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .s_axi_aclk    (s_axi_aclk),
    .s_axi_aresetn (s_axi_aresetn),
    .clear         (state_q == IDLE),
    .count_en      (state_q inside {WR_REQ, WR_RESP, RD_REQ, RD_RESP}),
    .expired       (timeout_hit)
  );

  assign rsp_timeout = rsp_timeout_q;
`else
  assign rsp_timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    awaddr_d    = awaddr_q;
    awvalid_d   = awvalid_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    araddr_d    = araddr_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
`ifdef AXIL_MASTER_TIMEOUT_EN
    rsp_timeout_d = rsp_timeout_q;
`endif

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          if (cmd_write) begin
            awaddr_d  = cmd_addr;
            wdata_d   = cmd_wdata;
            wstrb_d   = cmd_wstrb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR_REQ;
          end else begin
            araddr_d  = cmd_addr;
            arvalid_d = 1'b1;
            state_d   = RD_REQ;
          end
        end
      end
      WR_REQ: begin
        // AW and W complete independently; move on once both have handshaken.
        awvalid_d = awvalid_q && !m_axi_awready;
        wvalid_d  = wvalid_q && !m_axi_wready;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end
      end
      WR_RESP: begin
        if (m_axi_bvalid && bready_q) begin
          bready_d    = 1'b0;
          rsp_resp_d  = m_axi_bresp;
          rsp_rdata_d = '0;
          rsp_valid_d = 1'b1;
          state_d     = RSP;
        end
      end
      RD_REQ: begin
        if (arvalid_q && m_axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_RESP;
        end
      end
      RD_RESP: begin
        if (m_axi_rvalid && rready_q) begin
          rready_d    = 1'b0;
          rsp_rdata_d = m_axi_rdata;
          rsp_resp_d  = m_axi_rresp;
          rsp_valid_d = 1'b1;
          state_d     = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef AXIL_MASTER_TIMEOUT_EN
    if (state_q == IDLE && state_d != IDLE) begin
      rsp_timeout_d = 1'b0;
    end
    // A handshake that completes the transaction on the expiry edge wins.
    if (timeout_hit && state_d != RSP) begin
      awvalid_d     = 1'b0;
      wvalid_d      = 1'b0;
      bready_d      = 1'b0;
      arvalid_d     = 1'b0;
      rready_d      = 1'b0;
      rsp_resp_d    = RESP_SLVERR;
      rsp_rdata_d   = '0;
      rsp_timeout_d = 1'b1;
      rsp_valid_d   = 1'b1;
      state_d       = RSP;
    end
`endif

    cmd_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      awaddr_q    <= '0;
      awvalid_q   <= 1'b0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      araddr_q    <= '0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= RESP_OKAY;
`ifdef AXIL_MASTER_TIMEOUT_EN
      rsp_timeout_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      awaddr_q    <= awaddr_d;
      awvalid_q   <= awvalid_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      araddr_q    <= araddr_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
`ifdef AXIL_MASTER_TIMEOUT_EN
      rsp_timeout_q <= rsp_timeout_d;
`endif
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_axil_master.sv
// tb/tb_axil_master.sv - directed self-checking bench for axil_master with a register-file slave
module tb_axil_master;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int SW = DW / 8;
`ifdef AXIL_MASTER_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 256;
`endif

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [SW-1:0] cmd_wstrb = '0;
  logic          rsp_valid, rsp_ready = 1'b0, rsp_timeout;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic [AW-1:0] m_awaddr, m_araddr;
  logic [2:0]    m_awprot, m_arprot;
  logic          m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic          m_arvalid, m_arready, m_rvalid, m_rready;
  logic [DW-1:0] m_wdata, m_rdata;
  logic [SW-1:0] m_wstrb;
  logic [1:0]    m_bresp, m_rresp;

  axil_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .s_axi_aclk(clk), .s_axi_aresetn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .m_axi_awaddr(m_awaddr), .m_axi_awprot(m_awprot), .m_axi_awvalid(m_awvalid),
    .m_axi_awready(m_awready), .m_axi_wdata(m_wdata), .m_axi_wstrb(m_wstrb),
    .m_axi_wvalid(m_wvalid), .m_axi_wready(m_wready), .m_axi_bresp(m_bresp),
    .m_axi_bvalid(m_bvalid), .m_axi_bready(m_bready), .m_axi_araddr(m_araddr),
    .m_axi_arprot(m_arprot), .m_axi_arvalid(m_arvalid), .m_axi_arready(m_arready),
    .m_axi_rdata(m_rdata), .m_axi_rresp(m_rresp), .m_axi_rvalid(m_rvalid),
    .m_axi_rready(m_rready)
  );

  // Register-file slave with per-channel ready delays.
  int       aw_delay = 0, w_delay = 0, ar_delay = 0;
  bit       b_never = 1'b0, ar_never = 1'b0;
  logic [1:0] b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;
  int       aw_wait, w_wait, ar_wait;
  logic     aw_got, w_got;
  logic [AW-1:0] aw_addr_l;
  logic [DW-1:0] w_data_l;
  logic [SW-1:0] w_strb_l;
  logic [DW-1:0] mem [4];
  logic     aw_now, w_now;
  logic [AW-1:0] addr_sel;
  logic [DW-1:0] data_sel;
  logic [SW-1:0] strb_sel;

  assign m_awready = (aw_wait >= aw_delay);
  assign m_wready  = (w_wait >= w_delay);
  assign m_arready = !ar_never && (ar_wait >= ar_delay);
  assign aw_now    = m_awvalid && m_awready;
  assign w_now     = m_wvalid && m_wready;
  assign addr_sel  = aw_now ? m_awaddr : aw_addr_l;
  assign data_sel  = w_now ? m_wdata : w_data_l;
  assign strb_sel  = w_now ? m_wstrb : w_strb_l;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      aw_wait <= 0; w_wait <= 0; ar_wait <= 0;
      aw_got <= 1'b0; w_got <= 1'b0;
      aw_addr_l <= '0; w_data_l <= '0; w_strb_l <= '0;
      m_bvalid <= 1'b0; m_bresp <= 2'b00;
      m_rvalid <= 1'b0; m_rresp <= 2'b00; m_rdata <= '0;
    end else begin
      aw_wait <= (m_awvalid && !m_awready) ? aw_wait + 1 : 0;
      w_wait  <= (m_wvalid && !m_wready) ? w_wait + 1 : 0;
      ar_wait <= (m_arvalid && !m_arready) ? ar_wait + 1 : 0;
      if ((aw_got || aw_now) && (w_got || w_now)) begin
        for (int b = 0; b < SW; b++)
          if (strb_sel[b]) mem[addr_sel[3:2]][8*b +: 8] <= data_sel[8*b +: 8];
        if (!b_never) begin
          m_bvalid <= 1'b1;
          m_bresp  <= b_resp_cfg;
        end
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end else begin
        if (aw_now) begin aw_got <= 1'b1; aw_addr_l <= m_awaddr; end
        if (w_now) begin w_got <= 1'b1; w_data_l <= m_wdata; w_strb_l <= m_wstrb; end
      end
      if (m_bvalid && m_bready) m_bvalid <= 1'b0;
      if (m_arvalid && m_arready) begin
        m_rvalid <= 1'b1;
        m_rdata  <= mem[m_araddr[3:2]];
        m_rresp  <= r_resp_cfg;
      end
      if (m_rvalid && m_rready) m_rvalid <= 1'b0;
    end
  end

  int cyc = 0;
  int aw_hs_cnt = 0, w_hs_cnt = 0, rsp_cnt = 0, aw_only_cycles = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (aw_now) aw_hs_cnt <= aw_hs_cnt + 1;
    if (w_now) w_hs_cnt <= w_hs_cnt + 1;
    if (rsp_valid && rsp_ready) rsp_cnt <= rsp_cnt + 1;
  end
  always @(negedge clk) if (m_awvalid && !m_wvalid) aw_only_cycles <= aw_only_cycles + 1;

  int checks = 0;
  int errors = 0;

  task automatic send_cmd(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [SW-1:0] s, output int acc, output bit ok);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    ok  = cmd_ready;
    acc = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output bit ok);
    int n = 0;
    while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
    ok = rsp_valid;
  endtask

  task automatic ack_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic do_cmd(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [SW-1:0] s, output int lat, output logic [DW-1:0] rd,
                        output logic [1:0] rr, output logic to, output bit ok);
    int acc;
    bit ok1, ok2;
    send_cmd(w, a, d, s, acc, ok1);
    wait_rsp(ok2);
    lat = cyc - acc;
    rd  = rsp_rdata;
    rr  = rsp_resp;
    to  = rsp_timeout;
    ok  = ok1 && ok2;
    ack_rsp();
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_cmd_ready: got %b expected 0", cmd_ready); end
    checks++;
    if ({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, rsp_valid} !== 6'b0) begin
      errors++;
      $display("FAIL rst_valids: got %b expected 000000",
               {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, rsp_valid});
    end
    checks++;
    if ({m_awaddr, m_araddr, m_wdata, m_wstrb, rsp_rdata, rsp_resp, rsp_timeout, m_awprot, m_arprot} !== '0) begin
      errors++;
      $display("FAIL rst_payload: awaddr %h araddr %h wdata %h wstrb %h rdata %h resp %b to %b expected all 0",
               m_awaddr, m_araddr, m_wdata, m_wstrb, rsp_rdata, rsp_resp, rsp_timeout);
    end
    rstn = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_release_cmd_ready: got %b expected 0", cmd_ready); end
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_first_edge_cmd_ready: got %b expected 1", cmd_ready); end
  endtask

  task automatic test_write_read();
    int lat;
    logic [DW-1:0] rd;
    logic [1:0] rr;
    logic to;
    bit ok;
    do_cmd(1'b1, 4'h4, 32'hDEADBEEF, 4'hF, lat, rd, rr, to, ok);
    checks++;
    if (!ok || lat !== 3) begin errors++; $display("FAIL wr_latency: got %0d (ok %0d) expected 3", lat, ok); end
    checks++;
    if ({rr, to, rd} !== {2'b00, 1'b0, 32'h0}) begin
      errors++; $display("FAIL wr_rsp: resp %b to %b rdata %h expected 00 0 00000000", rr, to, rd);
    end
    do_cmd(1'b0, 4'h4, 32'h0, 4'h0, lat, rd, rr, to, ok);
    checks++;
    if (!ok || lat !== 3) begin errors++; $display("FAIL rd_latency: got %0d (ok %0d) expected 3", lat, ok); end
    checks++;
    if (rd !== 32'hDEADBEEF || rr !== 2'b00 || to !== 1'b0) begin
      errors++; $display("FAIL rd_data: rdata %h resp %b to %b expected deadbeef 00 0", rd, rr, to);
    end
  endtask

  task automatic test_strobe();
    int lat;
    logic [DW-1:0] rd;
    logic [1:0] rr;
    logic to;
    bit ok;
    do_cmd(1'b1, 4'h8, 32'h11223344, 4'hF, lat, rd, rr, to, ok);
    do_cmd(1'b1, 4'h8, 32'hAABBCCDD, 4'h5, lat, rd, rr, to, ok);
    do_cmd(1'b0, 4'h8, 32'h0, 4'h0, lat, rd, rr, to, ok);
    checks++;
    if (!ok || rd !== 32'h11BB33DD) begin errors++; $display("FAIL strobe_merge: got %h expected 11bb33dd", rd); end
    r_resp_cfg = 2'b11;
    do_cmd(1'b0, 4'h8, 32'h0, 4'h0, lat, rd, rr, to, ok);
    r_resp_cfg = 2'b00;
    checks++;
    if (!ok || rr !== 2'b11 || rd !== 32'h11BB33DD) begin
      errors++; $display("FAIL rd_decerr: resp %b rdata %h expected 11 11bb33dd", rr, rd);
    end
  endtask

  task automatic test_w_before_aw();
    int lat, aw0, w0, r0, o0;
    logic [DW-1:0] rd;
    logic [1:0] rr;
    logic to;
    bit ok;
    aw_delay = 3;
    aw0 = aw_hs_cnt; w0 = w_hs_cnt; r0 = rsp_cnt; o0 = aw_only_cycles;
    do_cmd(1'b1, 4'h0, 32'hCAFEF00D, 4'hF, lat, rd, rr, to, ok);
    @(negedge clk);
    aw_delay = 0;
    checks++;
    if (aw_hs_cnt - aw0 !== 1 || w_hs_cnt - w0 !== 1) begin
      errors++; $display("FAIL split_handshakes: aw %0d w %0d expected 1 1", aw_hs_cnt - aw0, w_hs_cnt - w0);
    end
    checks++;
    if (aw_only_cycles - o0 !== 3) begin
      errors++; $display("FAIL split_w_drops_first: awvalid-only cycles %0d expected 3", aw_only_cycles - o0);
    end
    checks++;
    if (!ok || lat !== 6 || rsp_cnt - r0 !== 1 || rr !== 2'b00) begin
      errors++; $display("FAIL split_rsp: lat %0d rsps %0d resp %b expected 6 1 00", lat, rsp_cnt - r0, rr);
    end
    do_cmd(1'b0, 4'h0, 32'h0, 4'h0, lat, rd, rr, to, ok);
    checks++;
    if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL split_readback: got %h expected cafef00d", rd); end
  endtask

  task automatic test_bresp_err();
    int lat;
    logic [DW-1:0] rd;
    logic [1:0] rr;
    logic to;
    bit ok;
    b_resp_cfg = 2'b10;
    do_cmd(1'b1, 4'hC, 32'h12345678, 4'hF, lat, rd, rr, to, ok);
    b_resp_cfg = 2'b00;
    checks++;
    if (!ok || rr !== 2'b10 || to !== 1'b0) begin
      errors++; $display("FAIL bresp_slverr: resp %b to %b expected 10 0", rr, to);
    end
  endtask

  task automatic test_rsp_backpressure();
    int acc;
    bit ok1, ok2, bad;
    send_cmd(1'b0, 4'h4, 32'h0, 4'h0, acc, ok1);
    wait_rsp(ok2);
    checks++;
    if (!(ok1 && ok2)) begin errors++; $display("FAIL bp_rsp_arrive: ok %0d %0d expected 1 1", ok1, ok2); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bad = (rsp_valid !== 1'b1) || (rsp_rdata !== 32'hDEADBEEF) || (rsp_resp !== 2'b00) || (cmd_ready !== 1'b0);
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL bp_hold_%0d: valid %b rdata %h resp %b cmd_ready %b expected 1 deadbeef 00 0",
                 i, rsp_valid, rsp_rdata, rsp_resp, cmd_ready);
      end
    end
    ack_rsp();
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release: valid %b cmd_ready %b expected 0 1", rsp_valid, cmd_ready);
    end
  endtask

`ifdef AXIL_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    int acc, n, ar_cycles;
    bit ok1;
    ar_never = 1'b1;
    send_cmd(1'b0, 4'h4, 32'h0, 4'h0, acc, ok1);
    n = 0; ar_cycles = 0;
    while (!rsp_valid && n < 40) begin
      if (m_arvalid) ar_cycles++;
      @(negedge clk);
      n++;
    end
    checks++;
    if (!rsp_valid || ar_cycles !== 8 || m_arvalid !== 1'b0) begin
      errors++; $display("FAIL to_wait: rsp_valid %b arvalid cycles %0d arvalid %b expected 1 8 0",
                         rsp_valid, ar_cycles, m_arvalid);
    end
    checks++;
    if (rsp_timeout !== 1'b1 || rsp_resp !== 2'b10 || rsp_rdata !== '0) begin
      errors++; $display("FAIL to_rsp: to %b resp %b rdata %h expected 1 10 00000000", rsp_timeout, rsp_resp, rsp_rdata);
    end
    ack_rsp();
    ar_never = 1'b0;
  endtask
`endif

  task automatic test_reset_mid_write();
    int acc, n, lat;
    bit ok1, ok;
    logic [DW-1:0] rd;
    logic [1:0] rr;
    logic to;
    b_never = 1'b1;
    send_cmd(1'b1, 4'h0, 32'h55AA55AA, 4'hF, acc, ok1);
    n = 0;
    while (!m_bready && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (m_bready !== 1'b1) begin errors++; $display("FAIL mid_reach_wr_resp: bready %b expected 1", m_bready); end
    rstn = 1'b0;
    #1;
    checks++;
    if ({m_bready, m_awvalid, m_wvalid, rsp_valid, cmd_ready} !== 5'b0) begin
      errors++; $display("FAIL mid_reset_outputs: got %b expected 00000",
                         {m_bready, m_awvalid, m_wvalid, rsp_valid, cmd_ready});
    end
    @(negedge clk);
    b_never = 1'b0;
    rstn = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin errors++; $display("FAIL mid_release: cmd_ready %b expected 0", cmd_ready); end
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL mid_first_edge: cmd_ready %b expected 1", cmd_ready); end
    do_cmd(1'b0, 4'h4, 32'h0, 4'h0, lat, rd, rr, to, ok);
    checks++;
    if (!ok || rd !== 32'hDEADBEEF || lat !== 3) begin
      errors++; $display("FAIL mid_recover_read: rdata %h lat %0d expected deadbeef 3", rd, lat);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_strobe();
    test_w_before_aw();
    test_bresp_err();
    test_rsp_backpressure();
`ifdef AXIL_MASTER_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d checks %0d errors", checks, errors);
    $fatal(1);
  end

endmodule
